wav_stream_ctrl: RTL and testbench

WAV_STREAM_CTRL -- requirements
Module: wav_stream_ctrl

---
 rtl/wav_stream_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_wav_stream_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wav_stream_ctrl.sv
// Streams a mono PCM WAV file byte-by-byte: a 44-byte RIFF/WAVE header followed
// by num_samples little-endian samples (16-bit) or offset-binary bytes (8-bit).
module wav_stream_ctrl #(
  parameter int FS            = 12500,
  parameter int BITS_PER_SAMP = 16,
  parameter int CHANNELS      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] num_samples,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done
);

  generate
    if (!(BITS_PER_SAMP == 8 || BITS_PER_SAMP == 16)) begin : g_bad_bits
      $error("wav_stream_ctrl: BITS_PER_SAMP must be 8 or 16");
    end
    if (CHANNELS != 1) begin : g_bad_channels
      $error("wav_stream_ctrl: only CHANNELS=1 is supported");
    end
  endgenerate

  localparam int          BW        = BITS_PER_SAMP / 8;
  localparam logic [31:0] BW32      = 32'(BW);
  localparam logic [31:0] FS32      = 32'(FS);
  localparam logic [31:0] BYTE_RATE = 32'(FS * CHANNELS * BW);
  localparam logic [15:0] CH16      = 16'(CHANNELS);
  localparam logic [15:0] ALIGN16   = 16'(CHANNELS * BW);
  localparam logic [15:0] BITS16    = 16'(BITS_PER_SAMP);
  localparam logic [5:0]  HDR_LAST  = 6'd43;

  typedef enum logic [2:0] {IDLE, HDR, SAMP_WAIT, SAMP_HI, DONE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  hdr_idx_reg, hdr_idx_next;
  logic [23:0] num_reg, num_next;
  logic [23:0] cnt_reg, cnt_next;
  logic [7:0]  hi_reg, hi_next;
  logic        m_valid_reg, m_valid_next;
  logic [7:0]  m_data_reg, m_data_next;
  logic        m_last_reg, m_last_next;

  logic [31:0] data_size;
  logic        xfer;
  logic        more;
  logic        accept;

  // Header viewed as eleven little-endian 32-bit words; idx[1:0] picks the byte.
  function automatic logic [7:0] hdr_byte(input logic [5:0] idx, input logic [31:0] dsize);
    logic [31:0] w;
    logic [31:0] sh;
    case (idx[5:2])
      4'd0:    w = 32'h4646_4952;             // "RIFF"
      4'd1:    w = dsize + 32'd36;
      4'd2:    w = 32'h4556_4157;             // "WAVE"
      4'd3:    w = 32'h2074_6D66;             // "fmt "
      4'd4:    w = 32'd16;
      4'd5:    w = {CH16, 16'd1};
      4'd6:    w = FS32;
      4'd7:    w = BYTE_RATE;
      4'd8:    w = {BITS16, ALIGN16};
      4'd9:    w = 32'h6174_6164;             // "data"
      4'd10:   w = dsize;
      default: w = 32'd0;
    endcase
    sh = w >> {idx[1:0], 3'b000};
    return sh[7:0];
  endfunction

  assign data_size = {8'd0, num_reg} * BW32;
  assign xfer      = m_valid_reg && m_ready;
  assign more      = (cnt_reg != num_reg);
  // Once every sample has been taken the trailing byte may still be pending.
  assign s_ready   = (state_reg == SAMP_WAIT) && more && (!m_valid_reg || m_ready);
  assign accept    = s_ready && s_valid;

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_last  = m_last_reg;
  assign busy    = (state_reg == HDR) || (state_reg == SAMP_WAIT) || (state_reg == SAMP_HI);
  assign done    = (state_reg == DONE);

  always_comb begin
    state_next   = state_reg;
    hdr_idx_next = hdr_idx_reg;
    num_next     = num_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    m_last_next  = m_last_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = HDR;
          num_next     = num_samples;
          cnt_next     = 24'd0;
          hdr_idx_next = 6'd0;
          m_valid_next = 1'b1;
          m_data_next  = hdr_byte(6'd0, 32'd0);
          m_last_next  = 1'b0;
        end
      end
      HDR: begin
        if (xfer) begin
          if (hdr_idx_reg == HDR_LAST) begin
            m_valid_next = 1'b0;
            m_last_next  = 1'b0;
            state_next   = m_last_reg ? DONE : SAMP_WAIT;
          end else begin
            hdr_idx_next = hdr_idx_reg + 6'd1;
            m_data_next  = hdr_byte(hdr_idx_reg + 6'd1, data_size);
            m_last_next  = (hdr_idx_reg + 6'd1 == HDR_LAST) && (num_reg == 24'd0);
          end
        end
      end
      SAMP_WAIT: begin
        if (accept) begin
          cnt_next     = cnt_reg + 24'd1;
          m_valid_next = 1'b1;
          if (BW == 2) begin
            m_data_next = s_data[7:0];
            hi_next     = s_data[15:8];
            m_last_next = 1'b0;
            state_next  = SAMP_HI;
          end else begin
            // Unsigned 8-bit WAV: top byte with the sign bit flipped.
            m_data_next = s_data[15:8] ^ 8'h80;
            m_last_next = (cnt_reg + 24'd1 == num_reg);
          end
        end else if (xfer) begin
          m_valid_next = 1'b0;
          m_last_next  = 1'b0;
          if (m_last_reg) state_next = DONE;
        end
      end
      SAMP_HI: begin
        if (xfer) begin
          m_data_next = hi_reg;
          m_last_next = !more;
          state_next  = SAMP_WAIT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      hdr_idx_reg <= 6'd0;
      num_reg     <= 24'd0;
      cnt_reg     <= 24'd0;
      hi_reg      <= 8'd0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= 8'd0;
      m_last_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hdr_idx_reg <= hdr_idx_next;
      num_reg     <= num_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      m_last_reg  <= m_last_next;
    end
  end

endmodule

// File: tb/tb_wav_stream_ctrl.sv
// Self-checking bench: a 16-bit and an 8-bit instance share stimulus; each stream
// is compared byte-for-byte against a WAV image built from the file format rules.
module tb_wav_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, s_valid, m_ready;
  logic [23:0] num_samples;
  logic [15:0] s_data;

  logic       s_ready16, m_valid16, m_last16, busy16, done16;
  logic [7:0] m_data16;
  logic       s_ready8, m_valid8, m_last8, busy8, done8;
  logic [7:0] m_data8;

  wav_stream_ctrl #(.FS(12500), .BITS_PER_SAMP(16), .CHANNELS(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .s_valid(s_valid), .s_ready(s_ready16), .s_data(s_data),
    .m_valid(m_valid16), .m_ready(m_ready), .m_data(m_data16), .m_last(m_last16),
    .busy(busy16), .done(done16)
  );

  wav_stream_ctrl #(.FS(12500), .BITS_PER_SAMP(8), .CHANNELS(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .m_valid(m_valid8), .m_ready(m_ready), .m_data(m_data8), .m_last(m_last8),
    .busy(busy8), .done(done8)
  );

  logic       sel8;
  logic       o_sr, o_mv, o_ml, o_busy, o_done;
  logic [7:0] o_md;
  assign o_sr   = sel8 ? s_ready8  : s_ready16;
  assign o_mv   = sel8 ? m_valid8  : m_valid16;
  assign o_ml   = sel8 ? m_last8   : m_last16;
  assign o_md   = sel8 ? m_data8   : m_data16;
  assign o_busy = sel8 ? busy8     : busy16;
  assign o_done = sel8 ? done8     : done16;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] samp_q[$];

  task automatic push_le(input logic [31:0] v, input int nbytes);
    for (int k = 0; k < nbytes; k++) exp_q.push_back(8'((v >> (8 * k)) & 32'hFF));
  endtask

  task automatic push_str(input logic [31:0] s);
    for (int k = 3; k >= 0; k--) exp_q.push_back(8'((s >> (8 * k)) & 32'hFF));
  endtask

  // Reference WAV image: header fields from the format rules, then sample bytes.
  task automatic build_exp(input int n, input int bw);
    int ds, v;
    exp_q.delete();
    while (samp_q.size() < n) samp_q.push_back(16'($urandom));
    ds = n * bw;
    push_str("RIFF"); push_le(32'(ds + 36), 4);
    push_str("WAVE"); push_str("fmt ");
    push_le(32'd16, 4); push_le(32'd1, 2); push_le(32'd1, 2);
    push_le(32'd12500, 4); push_le(32'(12500 * bw), 4);
    push_le(32'(bw), 2); push_le(32'(bw * 8), 2);
    push_str("data"); push_le(32'(ds), 4);
    for (int i = 0; i < n; i++) begin
      if (bw == 2) push_le({16'd0, samp_q[i]}, 2);
      else begin
        v = int'($signed(samp_q[i]));
        v = (v >>> 8) + 128;
        exp_q.push_back(8'(v));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    num_samples = 24'd0; s_data = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one stream from the current negedge; abort_at>=0 returns right after
  // that byte index has transferred, leaving the stream unfinished.
  task automatic run_stream(input int n, input int bw, input int rdy_pct, input int vld_pct,
                            input int hold_at, input bit glitch, input int abort_at);
    int idx, sidx, total, cyc, hold_cnt, t;
    bit prev_stall, prev_xfer, bubble_exp, finished, glitched;
    logic [7:0] prev_data, md;
    logic prev_last, mv, ml, sr;
    build_exp(n, bw);
    total = exp_q.size();
    idx = 0; sidx = 0; cyc = 0; hold_cnt = 0;
    prev_stall = 0; prev_xfer = 0; bubble_exp = 0; finished = 0; glitched = 0;
    prev_data = 8'd0; prev_last = 1'b0;
    start = 1'b1; num_samples = 24'(n); s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 3000) begin
      if (abort_at >= 0 && idx > abort_at) begin
        m_ready = 1'b0; s_valid = 1'b0;
        return;
      end
      if (hold_at >= 0 && idx == hold_at && hold_cnt < 5) begin
        m_ready = 1'b0; hold_cnt++;
      end else m_ready = ($urandom_range(99) < rdy_pct);
      if (sidx < n) begin
        s_valid = ($urandom_range(99) < vld_pct); s_data = samp_q[sidx];
      end else begin
        s_valid = 1'($urandom_range(1)); s_data = 16'($urandom);
      end
      if (glitch && !glitched && idx == 5) begin
        start = 1'b1; num_samples = 24'd7; glitched = 1;
      end else start = 1'b0;
      #1;
      mv = o_mv; md = o_md; ml = o_ml; sr = o_sr;
      if (cyc == 0) begin
        vectors++;
        if (mv !== 1'b1 || md !== 8'h52) begin
          miscompares++;
          $display("FAIL first_byte: got valid=%b data=%h, want valid=1 data=52", mv, md);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (mv !== 1'b1 || md !== prev_data || ml !== prev_last) begin
          miscompares++;
          $display("FAIL stall_stable idx=%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   idx, mv, md, ml, prev_data, prev_last);
        end
      end
      if (prev_xfer && bubble_exp) begin
        vectors++;
        if (mv !== 1'b1) begin
          miscompares++;
          $display("FAIL no_bubble idx=%0d: got m_valid=%b, want 1", idx, mv);
        end
      end
      vectors++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_during idx=%0d: got busy=%b done=%b, want busy=1 done=0",
                 idx, o_busy, o_done);
      end
      if (idx < 44 && sr !== 1'b0) begin
        vectors++; miscompares++;
        $display("FAIL s_ready_hdr idx=%0d: got s_ready=%b, want 0", idx, sr);
      end
      prev_xfer = mv && m_ready;
      prev_stall = mv && !m_ready;
      prev_data = md; prev_last = ml;
      if (mv && m_ready) begin
        vectors++;
        if (idx >= total || md !== exp_q[idx] || ml !== (idx == total - 1)) begin
          miscompares++;
          $display("FAIL byte[%0d]: got data=%h last=%b, want data=%h last=%b", idx, md, ml,
                   (idx < total) ? exp_q[idx] : 8'hxx, (idx == total - 1));
        end
        t = idx;
        bubble_exp = (t < 43) || (bw == 2 && t >= 44 && ((t - 44) % 2 == 0));
        idx++;
        if (idx >= total) finished = 1;
      end
      if (sr && s_valid) begin
        vectors++;
        if (sidx >= n) begin
          miscompares++;
          $display("FAIL extra_sample: got accept with %0d of %0d taken, want none", sidx, n);
        end
        sidx++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0; s_valid = 1'b0; start = 1'b0;
    if (!finished) begin
      vectors++; miscompares++;
      $display("FAIL timeout: got %0d bytes, want %0d", idx, total);
      return;
    end
    #1;
    vectors++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_mv !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b busy=%b valid=%b, want 1 0 0", o_done, o_busy, o_mv);
    end
    @(negedge clk); #1;
    vectors++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after: got done=%b busy=%b, want 0 0", o_done, o_busy);
    end
    @(negedge clk);
    $display("stream bw=%0d n=%0d bytes=%0d cycles=%0d", bw, n, total, cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    num_samples = 24'd0; s_data = 16'd0; sel8 = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({s_ready16, m_valid16, m_last16, busy16, done16, m_data16} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset16: got %b, want 0", {s_ready16, m_valid16, m_last16, busy16, done16, m_data16});
    end
    vectors++;
    if ({s_ready8, m_valid8, m_last8, busy8, done8, m_data8} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset8: got %b, want 0", {s_ready8, m_valid8, m_last8, busy8, done8, m_data8});
    end
    do_reset();
  endtask

  task automatic test_basic16();
    sel8 = 1'b0; do_reset();
    samp_q = '{16'h1234, 16'hFFFE, 16'h0001};
    run_stream(3, 2, 100, 100, -1, 0, -1);
  endtask

  task automatic test_zero();
    sel8 = 1'b0; do_reset(); samp_q.delete();
    run_stream(0, 2, 100, 100, -1, 0, -1);
    sel8 = 1'b1; do_reset(); samp_q.delete();
    run_stream(0, 1, 60, 100, -1, 0, -1);
  endtask

  task automatic test_hold();
    sel8 = 1'b0; do_reset(); samp_q.delete();
    run_stream(2, 2, 100, 100, 10, 0, -1);
  endtask

  task automatic test_8bit();
    sel8 = 1'b1; do_reset();
    samp_q = '{16'h8000, 16'h7FFF};
    run_stream(2, 1, 100, 100, -1, 0, -1);
    samp_q.delete();
    run_stream(6, 1, 50, 50, -1, 0, -1);
  endtask

  task automatic test_start_ignored();
    sel8 = 1'b0; do_reset(); samp_q.delete();
    run_stream(2, 2, 80, 80, -1, 1, -1);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      sel8 = 1'(r % 2); do_reset(); samp_q.delete();
      n = int'($urandom_range(1, 20));
      run_stream(n, sel8 ? 1 : 2, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                 -1, 0, -1);
    end
  endtask

  task automatic test_back_to_back();
    sel8 = 1'b0; do_reset();
    samp_q.delete(); run_stream(4, 2, 70, 70, -1, 0, -1);
    samp_q.delete(); run_stream(1, 2, 100, 100, -1, 0, -1);
  endtask

  task automatic test_reset_mid();
    sel8 = 1'b0; do_reset();
    samp_q = '{16'h1234, 16'hFFFE, 16'h0001};
    run_stream(3, 2, 100, 100, -1, 0, 45);
    rst_n = 1'b0; #1;
    vectors++;
    if ({o_sr, o_mv, o_ml, o_busy, o_done, o_md} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %b, want 0", {o_sr, o_mv, o_ml, o_busy, o_done, o_md});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (o_mv !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_resume: got valid=%b busy=%b, want 0 0", o_mv, o_busy);
    end
    @(negedge clk);
    samp_q.delete();
    run_stream(2, 2, 100, 100, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic16();
    test_zero();
    test_hold();
    test_8bit();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
